// File: rtl/sobel_threshold_stage.sv
// Sobel L1 magnitude, threshold compare and per-frame edge counter.
// Two-stage valid/ready pipeline; threshold latched on each SOF beat.
module sobel_threshold_stage #(
  parameter int GW          = 11,
  parameter int CNT_W       = 20,
  parameter int THR_DEFAULT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           threshold,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [GW-1:0] s_gx,
  input  logic signed [GW-1:0] s_gy,
  input  logic                 s_sof,
  input  logic                 s_eof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           m_pixel,
  output logic                 m_sof,
  output logic                 m_eof,
  output logic [CNT_W-1:0]     edge_count,
  output logic                 edge_count_valid
);

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic       eof;
    logic [7:0] mag;
    logic [7:0] thr;
  } s1_t;

  s1_t            s1;
  logic           adv;
  logic           acc;
  logic [7:0]     thr_active;
  logic [7:0]     thr_sel;
  logic [GW-1:0]  ax;
  logic [GW-1:0]  ay;
  logic [GW:0]    sum;
  logic [7:0]     mag;
  logic [CNT_W-1:0] running;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] nxt;
  logic           hs;

  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign acc     = s_valid && adv;
  assign hs      = m_valid && m_ready;

  // Magnitude and threshold selection for the incoming beat
  always_comb begin
    ax  = s_gx[GW-1] ? -s_gx : s_gx;
    ay  = s_gy[GW-1] ? -s_gy : s_gy;
    sum = {1'b0, ax} + {1'b0, ay};
    mag = (sum > (GW+1)'(255)) ? 8'hFF : sum[7:0];
    thr_sel = s_sof ? threshold : thr_active;
  end

  // Threshold latch, updated only by accepted SOF beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thr_active <= 8'(THR_DEFAULT);
    else if (acc && s_sof) thr_active <= threshold;
  end

  // Stage 1: register magnitude, framing and selected threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1 <= '0;
    else if (adv) begin
      s1.valid <= s_valid;
      s1.sof   <= s_valid && s_sof;
      s1.eof   <= s_valid && s_eof;
      s1.mag   <= mag;
      s1.thr   <= thr_sel;
    end
  end

  // Stage 2: compare and drive the output stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pixel <= 8'h00;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (adv) begin
      m_valid <= s1.valid;
      m_pixel <= (s1.valid && s1.mag >= s1.thr) ? 8'hFF : 8'h00;
      m_sof   <= s1.sof;
      m_eof   <= s1.eof;
    end
  end

  // Next running count for the beat leaving on this handshake
  always_comb begin
    base = m_sof ? '0 : running;
    nxt  = (m_pixel[0] && base != '1) ? base + CNT_W'(1) : base;
  end

  // Edge counter, published on the EOF handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running          <= '0;
      edge_count       <= '0;
      edge_count_valid <= 1'b0;
    end else begin
      edge_count_valid <= 1'b0;
      if (hs) begin
        if (m_eof) begin
          edge_count       <= nxt;
          edge_count_valid <= 1'b1;
          running          <= '0;
        end else begin
          running <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_threshold_stage.sv
// Bench for sobel_threshold_stage.
// Scoreboard of expected output beats plus per-scenario checks.
module tb_sobel_threshold_stage;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        threshold = 8'h10;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [10:0] s_gx = '0;
  logic signed [10:0] s_gy = '0;
  logic              s_sof = 1'b0;
  logic              s_eof = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [7:0]        m_pixel;
  logic              m_sof;
  logic              m_eof;
  logic [19:0]       edge_count;
  logic              edge_count_valid;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t q[$];
  int    ncmp  = 0;
  int    nfail = 0;
  int    thr_m = 128;

  sobel_threshold_stage #(.GW(11), .CNT_W(20), .THR_DEFAULT(128)) dut (
    .clk(clk), .rst(rst), .threshold(threshold),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_gx(s_gx), .s_gy(s_gy), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel),
    .m_sof(m_sof), .m_eof(m_eof),
    .edge_count(edge_count), .edge_count_valid(edge_count_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output handshake must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      ncmp++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL sb_extra: got pix=%h sof=%b eof=%b, required none",
                 m_pixel, m_sof, m_eof);
      end else begin
        beat_t e;
        e = q.pop_front();
        if ({m_pixel, m_sof, m_eof} !== {e.pix, e.sof, e.eof}) begin
          nfail++;
          $display("FAIL sb_beat: got pix=%h sof=%b eof=%b, required pix=%h sof=%b eof=%b",
                   m_pixel, m_sof, m_eof, e.pix, e.sof, e.eof);
        end
      end
    end
  end

  task automatic drive(input int gx, input int gy, input logic sof, input logic eof);
    int t = 0;
    int ax, ay, mag;
    beat_t e;
    s_valid = 1'b1;
    s_gx = 11'(gx);
    s_gy = 11'(gy);
    s_sof = sof;
    s_eof = eof;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      ncmp++;
      nfail++;
      $display("FAIL accept_timeout: s_ready=%b, required 1", s_ready);
    end else begin
      if (sof) thr_m = int'(threshold);
      ax  = gx < 0 ? -gx : gx;
      ay  = gy < 0 ? -gy : gy;
      mag = (ax + ay > 255) ? 255 : ax + ay;
      e.pix = (mag >= thr_m) ? 8'hFF : 8'h00;
      e.sof = sof;
      e.eof = eof;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eof = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d beats outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    ncmp++;
    if ({m_valid, m_pixel, m_sof, m_eof} !== 11'd0) begin
      nfail++;
      $display("FAIL reset_out: got v=%b pix=%h sof=%b eof=%b, required all 0",
               m_valid, m_pixel, m_sof, m_eof);
    end
    ncmp++;
    if (edge_count !== 20'd0 || edge_count_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_cnt: got cnt=%0d v=%b, required 0 0",
               edge_count, edge_count_valid);
    end
    ncmp++;
    if (s_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ready: got %b, required 1", s_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    threshold = 8'h10;
    drive(100, -50, 1'b0, 1'b0);
    ncmp++;
    if (m_valid !== 1'b0) begin
      nfail++;
      $display("FAIL latency_early: m_valid=%b one cycle after accept, required 0", m_valid);
    end
    @(posedge clk);
    #1;
    ncmp++;
    if (m_valid !== 1'b1 || m_pixel !== 8'hFF) begin
      nfail++;
      $display("FAIL latency_2: got v=%b pix=%h, required 1 ff", m_valid, m_pixel);
    end
    drive(60, -60, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_threshold_latch();
    threshold = 8'h40;
    drive(32, 32, 1'b1, 1'b0);
    threshold = 8'hF0;
    drive(32, 32, 1'b0, 1'b0);
    drive(20, 20, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_saturation();
    threshold = 8'hFF;
    drive(-1024, -1024, 1'b1, 1'b0);
    drive(0, 254, 1'b0, 1'b0);
    drive(1023, 1023, 1'b0, 1'b0);
    drive(200, 54, 1'b0, 1'b0);
    drive(200, 55, 1'b0, 1'b0);
    threshold = 8'h00;
    drive(0, 0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    int t = 0;
    logic [7:0] p0;
    logic s0, e0;
    threshold = 8'd128;
    m_ready = 1'b0;
    fork
      begin
        drive(200, 0, 1'b1, 1'b0);
        drive(10, 0, 1'b0, 1'b0);
        drive(0, 130, 1'b0, 1'b0);
        drive(5, 5, 1'b0, 1'b0);
        drive(-128, 0, 1'b0, 1'b0);
        drive(-1, -1, 1'b0, 1'b1);
      end
    join_none
    while (!m_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    ncmp++;
    if (!m_valid) begin
      nfail++;
      $display("FAIL bp_first: m_valid=%b, required 1", m_valid);
    end
    p0 = m_pixel;
    s0 = m_sof;
    e0 = m_eof;
    repeat (4) begin
      @(posedge clk);
      #1;
      ncmp++;
      if (m_valid !== 1'b1 || m_pixel !== p0 || m_sof !== s0 || m_eof !== e0) begin
        nfail++;
        $display("FAIL bp_hold: got v=%b pix=%h sof=%b eof=%b, required 1 %h %b %b",
                 m_valid, m_pixel, m_sof, m_eof, p0, s0, e0);
      end
      ncmp++;
      if (s_ready !== 1'b0) begin
        nfail++;
        $display("FAIL bp_ready: got %b, required 0", s_ready);
      end
    end
    m_ready = 1'b1;
    wait fork;
    drain();
  endtask

  task automatic test_frame_count();
    int lens[3]  = '{10, 3, 1};
    int masks[3] = '{32'h224, 32'h2, 32'h1};
    int exps[3]  = '{3, 1, 1};
    threshold = 8'd100;
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int pulses = 0;
      logic prev_eof_hs = 1'b0;
      fork
        begin
          for (int i = 0; i < lens[f]; i++) begin
            if (masks[f][i]) drive(150, 0, i == 0, i == lens[f] - 1);
            else drive(10, 0, i == 0, i == lens[f] - 1);
          end
        end
        begin
          for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (edge_count_valid) begin
              pulses++;
              ncmp++;
              if (edge_count !== 20'(exps[f]) || !prev_eof_hs) begin
                nfail++;
                $display("FAIL frame%0d_count: got cnt=%0d eofhs=%b, required %0d 1",
                         f, edge_count, prev_eof_hs, exps[f]);
              end
            end
            prev_eof_hs = m_valid && m_ready && m_eof;
          end
        end
      join
      ncmp++;
      if (pulses != 1) begin
        nfail++;
        $display("FAIL frame%0d_pulses: got %0d, required 1", f, pulses);
      end
      drain();
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    threshold = 8'h30;
    m_ready = 1'b1;
    drive(150, 0, 1'b1, 1'b0);
    drive(150, 0, 1'b0, 1'b0);
    drive(10, 0, 1'b0, 1'b0);
    drive(150, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    q.delete();
    thr_m = 128;
    ncmp++;
    if (m_valid !== 1'b0) begin
      nfail++;
      $display("FAIL mid_rst_valid: got %b, required 0", m_valid);
    end
    ncmp++;
    if (edge_count !== 20'd0 || edge_count_valid !== 1'b0) begin
      nfail++;
      $display("FAIL mid_rst_cnt: got cnt=%0d v=%b, required 0 0",
               edge_count, edge_count_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(100, 0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (edge_count_valid) pulses++;
    end
    ncmp++;
    if (pulses != 1 || edge_count !== 20'd0) begin
      nfail++;
      $display("FAIL mid_rst_after: got pulses=%0d cnt=%0d, required 1 0",
               pulses, edge_count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold_latch();
    test_saturation();
    test_backpressure();
    test_frame_count();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
